// File: rtl/noc_credit_tx.sv
// noc_credit_tx: credit-based transmitter for one NoC router output port.
// Flits from a local ready/valid source are registered onto a link that has
// no backpressure wire. A credit counter, starting at DEPTH, makes sure the
// far-end DEPTH-entry FIFO is never overrun. Wormhole framing is tracked so
// that a packet stalled mid-flight for STALL_MAX cycles raises a sticky flag.
//
// Optional feature macro: NOC_TX_CREDIT_CHECK_EN
//   defined   -> a credit return arriving at full credit sets sticky credit_err
//   undefined -> credit_err is tied low; surplus returns are still dropped
module noc_credit_tx #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 4,
  parameter int STALL_MAX = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           s_data,
  input  logic                       s_last,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [WIDTH-1:0]           tx_data,
  output logic                       tx_last,
  output logic                       tx_valid,
  input  logic                       credit_return,
  output logic [$clog2(DEPTH+1)-1:0] credits,
  output logic                       in_packet,
  output logic                       stall_timeout,
  output logic                       credit_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STALL_MAX + 1);

  localparam logic [CW-1:0] CRED_FULL = CW'(DEPTH);
  localparam logic [SW-1:0] STALL_TOP = SW'(STALL_MAX);

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  state_t            state;
  logic [CW-1:0]     cred_q;
  logic [SW-1:0]     stall_cnt;
  logic [WIDTH-1:0]  data_p1;
  logic              last_p1;
  logic              vld_p1;
  logic              accept;
  logic              ret_ok;

  // Saturating increment for the stall counter.
  function automatic logic [SW-1:0] stall_sat_inc(input logic [SW-1:0] v);
    if (v >= STALL_TOP) begin
      return STALL_TOP;
    end
    return v + SW'(1);
  endfunction

  // Ready is decoded from the registered count only, never from credit_return.
  assign s_ready = (cred_q != '0);
  assign accept  = s_valid && s_ready;
  // A return at full credit has no matching outstanding flit and is dropped.
  assign ret_ok  = credit_return && (cred_q != CRED_FULL);

  // Credit counter: minus one per accepted flit, plus one per legal return.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cred_q <= CRED_FULL;
    end else begin
      case ({accept, ret_ok})
        2'b10:   cred_q <= cred_q - CW'(1);
        2'b01:   cred_q <= cred_q + CW'(1);
        default: cred_q <= cred_q;
      endcase
    end
  end

  // ---- stage p0 -> p1: register accepted flit onto the link ----
  // Link register: capture payload on accept, pulse valid for exactly one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        data_p1 <= s_data;
        last_p1 <= s_last;
      end
    end
  end

  // Framing FSM: a non-tail accept opens a packet, a tail accept closes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (accept) begin
      state <= s_last ? IDLE : PKT;
    end
  end

  // Stall counter: counts no-credit cycles inside a packet, cleared by
  // any accept or whenever no packet is open.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (accept || (state == IDLE)) begin
      stall_cnt <= '0;
    end else if (!s_ready) begin
      stall_cnt <= stall_sat_inc(stall_cnt);
    end
  end

  // Sticky timeout, set the cycle after the counter reaches its limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_timeout <= 1'b0;
    end else if (stall_cnt == STALL_TOP) begin
      stall_timeout <= 1'b1;
    end
  end

`ifdef NOC_TX_CREDIT_CHECK_EN
  logic cred_err_q;

  // Sticky overflow flag: a return arrived while already holding every credit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cred_err_q <= 1'b0;
    end else if (credit_return && (cred_q == CRED_FULL)) begin
      cred_err_q <= 1'b1;
    end
  end

  assign credit_err = cred_err_q;
`else
  assign credit_err = 1'b0;
`endif

  assign tx_data   = data_p1;
  assign tx_last   = last_p1;
  assign tx_valid  = vld_p1;
  assign credits   = cred_q;
  assign in_packet = (state == PKT);

endmodule

// File: tb/tb_noc_credit_tx.sv
// Self-checking bench for noc_credit_tx (DEPTH=4, STALL_MAX=8).
// The reference model tracks downstream FIFO occupancy rather than credits.
module tb_noc_credit_tx;

  localparam int WIDTH     = 64;
  localparam int DEPTH     = 4;
  localparam int STALL_MAX = 8;
  localparam int CW        = $clog2(DEPTH + 1);
`ifdef NOC_TX_CREDIT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_last = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] tx_data;
  logic             tx_last;
  logic             tx_valid;
  logic             credit_return = 1'b0;
  logic [CW-1:0]    credits;
  logic             in_packet;
  logic             stall_timeout;
  logic             credit_err;

  int tests = 0;
  int fails = 0;

  noc_credit_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STALL_MAX(STALL_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_last(s_last),
    .s_valid(s_valid), .s_ready(s_ready), .tx_data(tx_data),
    .tx_last(tx_last), .tx_valid(tx_valid), .credit_return(credit_return),
    .credits(credits), .in_packet(in_packet),
    .stall_timeout(stall_timeout), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  // Reference model: occupancy of the far-end FIFO, open-packet flag,
  // number of stalled cycles seen inside the current packet.
  int               m_occ;
  bit               m_pkt;
  int               m_stall;
  bit               m_to, m_err, m_txv, m_txl;
  logic [WIDTH-1:0] m_txd;

  task automatic model_reset();
    m_occ = 0; m_pkt = 0; m_stall = 0; m_to = 0; m_err = 0;
    m_txv = 0; m_txl = 0; m_txd = '0;
  endtask

  task automatic model_step(input bit v, input bit l, input bit r, input logic [WIDTH-1:0] d);
    bit room, acc, empty;
    room  = (m_occ < DEPTH);
    acc   = v && room;
    empty = (m_occ == 0);
    if (m_stall >= STALL_MAX) m_to = 1;
    if (acc || !m_pkt) m_stall = 0;
    else if (!room && m_stall < STALL_MAX) m_stall++;
    if (acc) m_pkt = !l;
    m_txv = acc;
    if (acc) begin m_txd = d; m_txl = l; end
    if (r && empty) m_err = m_err | CHK;
    m_occ = m_occ + (acc ? 1 : 0) - ((r && !empty) ? 1 : 0);
  endtask

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("s_ready", WIDTH'(s_ready), WIDTH'(m_occ < DEPTH));
    check("credits", WIDTH'(credits), WIDTH'(DEPTH - m_occ));
    check("tx_valid", WIDTH'(tx_valid), WIDTH'(m_txv));
    check("tx_last", WIDTH'(tx_last), WIDTH'(m_txl));
    check("tx_data", tx_data, m_txd);
    check("in_packet", WIDTH'(in_packet), WIDTH'(m_pkt));
    check("stall_timeout", WIDTH'(stall_timeout), WIDTH'(m_to));
    check("credit_err", WIDTH'(credit_err), WIDTH'(m_err));
  endtask

  task automatic do_cycle(input bit v, input bit l, input bit r, input logic [WIDTH-1:0] d);
    s_valid = v; s_last = l; credit_return = r; s_data = d;
    @(posedge clk);
    model_step(v, l, r, d);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst_n = 0; s_valid = 0; s_last = 0; credit_return = 0; s_data = '0;
    @(posedge clk);
    model_reset();
    #1;
    rst_n = 1;
    compare_model();
  endtask

  typedef struct {
    bit               v, l, r;
    logic [WIDTH-1:0] d;
    int               cr;
    bit               txv, pkt, ovf_seen;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1, 0, 0, 64'hA0, 3, 1, 1, 0};  // head
    vecs[1]  = '{1, 0, 0, 64'hA1, 2, 1, 1, 0};
    vecs[2]  = '{1, 0, 0, 64'hA2, 1, 1, 1, 0};
    vecs[3]  = '{1, 1, 0, 64'hA3, 0, 1, 0, 0};  // tail, credits exhausted
    vecs[4]  = '{1, 0, 0, 64'hB0, 0, 0, 0, 0};  // no credit: blocked
    vecs[5]  = '{0, 0, 1, 64'h0,  1, 0, 0, 0};  // recovery
    vecs[6]  = '{1, 1, 0, 64'hC0, 0, 1, 0, 0};  // single-flit packet
    vecs[7]  = '{0, 0, 1, 64'h0,  1, 0, 0, 0};
    vecs[8]  = '{0, 0, 1, 64'h0,  2, 0, 0, 0};
    vecs[9]  = '{1, 1, 1, 64'hD0, 2, 1, 0, 0};  // accept + return at 2
    vecs[10] = '{0, 0, 1, 64'h0,  3, 0, 0, 0};
    vecs[11] = '{0, 0, 1, 64'h0,  4, 0, 0, 0};
    vecs[12] = '{0, 0, 1, 64'h0,  4, 0, 0, 1};  // overflow return
    vecs[13] = '{1, 0, 1, 64'hE0, 3, 1, 1, 1};  // overflow + accept
    vecs[14] = '{1, 1, 1, 64'hE1, 3, 1, 0, 1};  // legal return + tail

    do_reset();
    check("rst_credits", WIDTH'(credits), WIDTH'(DEPTH));
    check("rst_ready", WIDTH'(s_ready), WIDTH'(1));
    check("rst_tx_valid", WIDTH'(tx_valid), '0);
    check("rst_tx_data", tx_data, '0);

    // Table-driven directed vectors.
    for (int i = 0; i < 15; i++) begin
      do_cycle(vecs[i].v, vecs[i].l, vecs[i].r, vecs[i].d);
      check($sformatf("vec%0d_credits", i), WIDTH'(credits), WIDTH'(vecs[i].cr));
      check($sformatf("vec%0d_ready", i), WIDTH'(s_ready), WIDTH'(vecs[i].cr != 0));
      check($sformatf("vec%0d_tx_valid", i), WIDTH'(tx_valid), WIDTH'(vecs[i].txv));
      check($sformatf("vec%0d_in_packet", i), WIDTH'(in_packet), WIDTH'(vecs[i].pkt));
      check($sformatf("vec%0d_credit_err", i), WIDTH'(credit_err), WIDTH'(vecs[i].ovf_seen & CHK));
      if (vecs[i].txv) check($sformatf("vec%0d_tx_data", i), tx_data, vecs[i].d);
    end

    // Stall: head plus three body flits use up all credits, then wait.
    do_reset();
    for (int i = 0; i < 4; i++) do_cycle(1, 0, 0, WIDTH'(i + 16));
    check("stall_credits0", WIDTH'(credits), '0);
    for (int i = 0; i < STALL_MAX; i++) do_cycle(1, 0, 0, '0);
    check("stall_before", WIDTH'(stall_timeout), '0);
    do_cycle(0, 0, 0, '0);
    check("stall_set", WIDTH'(stall_timeout), WIDTH'(1));
    do_cycle(0, 0, 1, '0);
    do_cycle(1, 1, 0, 64'hF1);
    check("stall_tail_pkt", WIDTH'(in_packet), '0);
    check("stall_sticky", WIDTH'(stall_timeout), WIDTH'(1));

    // Reset in the middle of a packet.
    do_cycle(0, 0, 1, '0);
    do_cycle(1, 0, 0, 64'h55);
    check("mid_pkt", WIDTH'(in_packet), WIDTH'(1));
    do_reset();
    check("mid_rst_pkt", WIDTH'(in_packet), '0);
    check("mid_rst_to", WIDTH'(stall_timeout), '0);
    check("mid_rst_credits", WIDTH'(credits), WIDTH'(DEPTH));
    check("mid_rst_tx_data", tx_data, '0);

    // Randomized traffic against the model, with phases of scarce returns.
    for (int i = 0; i < 3000; i++) begin
      int rprob;
      rprob = ((i / 150) % 3 == 0) ? 12 : 2;
      if ($urandom_range(0, 599) == 0) do_reset();
      else do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, rprob) == 0, {$urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
